// File: rtl/raw_pattern_gen.sv
// -----------------------------------------------------------------------------
// raw_pattern_gen
// Raw Bayer (RGGB) video source for ISP bring-up and regression. It generates
// vsync/hsync/den timing with programmable blanking and one of four test
// patterns on an 8-bit raw sample stream.
//
// Ports
//   clk          in   pixel clock
//   reset        in   synchronous, active-high reset
//   enable       in   1 = run frames back-to-back, 0 = stop at the next frame end
//   pattern_sel  in   0 flat, 1 h-ramp, 2 colour bars, 3 moving diagonal
//   flat_val     in   sample value used by the flat pattern
//   out_vsync    out  frame sync, active-high, whole lines
//   out_hsync    out  line sync, active-high, on every line
//   out_den      out  active-pixel qualifier
//   out_raw      out  raw Bayer sample, 0 whenever out_den = 0
//   frame_cnt    out  completed-frame counter, wraps
//   busy         out  1 while a frame is in progress
// -----------------------------------------------------------------------------
module raw_pattern_gen #(
    parameter int source_h = 512,   // must be a multiple of 8
    parameter int source_v = 512,
    parameter int H_FP     = 16,
    parameter int HS_W     = 8,
    parameter int H_BP     = 16,
    parameter int V_FP     = 2,
    parameter int VS_W     = 2,
    parameter int V_BP     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [7:0]  flat_val,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_den,
    output logic [7:0]  out_raw,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int H_TOT = source_h + H_FP + HS_W + H_BP;
    localparam int V_TOT = source_v + V_FP + VS_W + V_BP;
    localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;
    localparam int BAR_W = source_h / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    // Per-bar channel masks, bit b = bar b (white .. black).
    localparam logic [7:0] R_MASK = 8'h33;
    localparam logic [7:0] G_MASK = 8'h0F;
    localparam logic [7:0] B_MASK = 8'h55;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   h_cnt, h_nxt;
    logic [VW-1:0]   v_cnt, v_nxt;
    logic [2:0]      bar_idx, bar_idx_nxt;
    logic [BW-1:0]   bar_sub, bar_sub_nxt;
    logic [15:0]     frame_cnt_nxt;
    logic [1:0]      pat_q, pat_cur;
    logic [7:0]      flat_q, flat_cur;
    logic            frame_start;
    logic            run_nxt, den_nxt, hs_nxt, vs_nxt;
    logic            bar_on;
    logic [7:0]      pix_nxt;

    // Next position: the counters name the pixel currently on the outputs, so
    // the outputs are registered from the position being moved to.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        h_nxt         = h_cnt;
        v_nxt         = v_cnt;
        bar_idx_nxt   = bar_idx;
        bar_sub_nxt   = bar_sub;
        frame_cnt_nxt = frame_cnt;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt   = RUN;
                    h_nxt       = '0;
                    v_nxt       = '0;
                    bar_idx_nxt = '0;
                    bar_sub_nxt = '0;
                end
            end
            RUN: begin
                if (h_cnt == H_LAST) begin
                    h_nxt       = '0;
                    bar_idx_nxt = '0;
                    bar_sub_nxt = '0;
                    if (v_cnt == V_LAST) begin
                        v_nxt         = '0;
                        frame_cnt_nxt = frame_cnt + 16'd1;
                        // enable is only looked at here, so frames are never cut short.
                        if (!enable) state_nxt = IDLE;
                    end else begin
                        v_nxt = v_cnt + VW'(1);
                    end
                end else begin
                    h_nxt = h_cnt + HW'(1);
                    // Bar index b = (x*8)/source_h, tracked incrementally.
                    if (bar_sub == BAR_LAST) begin
                        bar_sub_nxt = '0;
                        bar_idx_nxt = bar_idx + 3'd1;
                    end else begin
                        bar_sub_nxt = bar_sub + BW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pattern controls are captured on entry to (0,0) and used from that pixel on.
    assign run_nxt     = (state_nxt == RUN);
    assign frame_start = run_nxt && (h_nxt == '0) && (v_nxt == '0);
    assign pat_cur     = frame_start ? pattern_sel : pat_q;
    assign flat_cur    = frame_start ? flat_val    : flat_q;

    always_comb begin
        den_nxt = run_nxt && (int'(h_nxt) < source_h) && (int'(v_nxt) < source_v);
        hs_nxt  = run_nxt && (int'(h_nxt) >= source_h + H_FP)
                          && (int'(h_nxt) <  source_h + H_FP + HS_W);
        vs_nxt  = run_nxt && (int'(v_nxt) >= source_v + V_FP)
                          && (int'(v_nxt) <  source_v + V_FP + VS_W);

        // Bayer phase {y odd, x odd}: R, G / G, B.
        case ({v_nxt[0], h_nxt[0]})
            2'b00:   bar_on = R_MASK[bar_idx_nxt];
            2'b11:   bar_on = B_MASK[bar_idx_nxt];
            default: bar_on = G_MASK[bar_idx_nxt];
        endcase

        case (pat_cur)
            2'd0:    pix_nxt = flat_cur;
            2'd1:    pix_nxt = 8'(h_nxt);
            2'd2:    pix_nxt = bar_on ? 8'hFF : 8'h00;
            default: pix_nxt = 8'(h_nxt) + 8'(v_nxt) + frame_cnt_nxt[7:0];
        endcase
        if (!den_nxt) pix_nxt = 8'h00;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            bar_idx   <= '0;
            bar_sub   <= '0;
            pat_q     <= '0;
            flat_q    <= '0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            out_den   <= 1'b0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_raw   <= '0;
        end else begin
            state     <= state_nxt;
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            bar_idx   <= bar_idx_nxt;
            bar_sub   <= bar_sub_nxt;
            pat_q     <= pat_cur;
            flat_q    <= flat_cur;
            frame_cnt <= frame_cnt_nxt;
            busy      <= run_nxt;
            out_den   <= den_nxt;
            out_hsync <= hs_nxt;
            out_vsync <= vs_nxt;
            out_raw   <= pix_nxt;
        end
    end

endmodule

// File: tb/tb_raw_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_raw_pattern_gen
// Scoreboard bench for raw_pattern_gen in a small 8x4 configuration
// (H_TOT = 14, V_TOT = 7, 98 cycles per frame). Expected active samples are
// queued ahead of each frame; a monitor pops one per den cycle. Timing, busy
// and frame_cnt are checked cycle by cycle from the frame position.
// -----------------------------------------------------------------------------
module tb_raw_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [7:0]  flat_val;
    logic        out_vsync, out_hsync, out_den, busy;
    logic [7:0]  out_raw;
    logic [15:0] frame_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    raw_pattern_gen #(
        .source_h(8), .source_v(4),
        .H_FP(2), .HS_W(2), .H_BP(2),
        .V_FP(1), .VS_W(1), .V_BP(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .flat_val   (flat_val),
        .out_vsync  (out_vsync),
        .out_hsync  (out_hsync),
        .out_den    (out_den),
        .out_raw    (out_raw),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one expected sample per den cycle.
    always @(negedge clk) begin
        if (out_den) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check("pixel", 32'(out_raw), 32'(exp_q.pop_front()));
            end
        end
    end

    // Hand-derived bar lines: even rows R/G, odd rows G/B, bar width 1.
    logic [7:0] bars_even [8] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    logic [7:0] bars_odd  [8] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic push_const(input logic [7:0] v);
        repeat (32) exp_q.push_back(v);
    endtask

    task automatic push_bars();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                exp_q.push_back((y % 2 == 0) ? bars_even[x] : bars_odd[x]);
    endtask

    task automatic push_ramp();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                exp_q.push_back(8'(x));
    endtask

    task automatic push_diag(input int f);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                exp_q.push_back(8'(x + y + f));
    endtask

    // Walk one frame starting at the next clock edge. At cycle act_at the
    // pattern controls and enable are updated; at cycle reset_at reset is
    // raised and the walk stops.
    task automatic run_frame(input int fc, input int act_at, input logic [1:0] sel,
                             input logic [7:0] flat, input logic en, input int reset_at);
        int   h, v, dens;
        logic e_den, e_hs, e_vs;
        dens = 0;
        for (int i = 0; i < 98; i++) begin
            @(posedge clk); #1;
            h     = i % 14;
            v     = i / 14;
            e_den = (h < 8) && (v < 4);
            e_hs  = (h == 10) || (h == 11);
            e_vs  = (v == 5);
            check("den",   32'(out_den),   32'(e_den));
            check("hsync", 32'(out_hsync), 32'(e_hs));
            check("vsync", 32'(out_vsync), 32'(e_vs));
            check("busy",  32'(busy),      32'd1);
            if (!e_den) check("raw_blank", 32'(out_raw), 32'd0);
            if (i == 0 || i == 97) check("frame_cnt_in_frame", 32'(frame_cnt), 32'(fc));
            if (out_den) dens++;
            if (i == act_at) begin
                pattern_sel = sel;
                flat_val    = flat;
                enable      = en;
            end
            if (i == reset_at) begin
                reset = 1'b1;
                return;
            end
        end
        check("den_count", 32'(dens), 32'd32);
    endtask

    task automatic check_idle(input string name, input int fc);
        check({name, "_busy"},  32'(busy),      32'd0);
        check({name, "_den"},   32'(out_den),   32'd0);
        check({name, "_hsync"}, 32'(out_hsync), 32'd0);
        check({name, "_vsync"}, 32'(out_vsync), 32'd0);
        check({name, "_raw"},   32'(out_raw),   32'd0);
        check({name, "_fcnt"},  32'(frame_cnt), 32'(fc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        flat_val    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 0);

        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("idle_disabled", 0);

        // Flat 5A; controls changed mid-frame must not affect this frame.
        pattern_sel = 2'd0;
        flat_val    = 8'h5A;
        enable      = 1'b1;
        push_const(8'h5A);
        run_frame(0, 20, 2'd2, 8'h11, 1'b1, -1);

        push_bars();
        run_frame(1, 20, 2'd1, 8'h11, 1'b1, -1);

        push_ramp();
        run_frame(2, 20, 2'd3, 8'h11, 1'b1, -1);

        // Diagonal with f = 3; enable dropped at cycle 40, frame must complete.
        push_diag(3);
        run_frame(3, 40, 2'd3, 8'h11, 1'b0, -1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_idle("stopped", 4);
        end

        // Re-enable: pixel (0,0) on the next cycle; reset at cycle 50.
        pattern_sel = 2'd0;
        flat_val    = 8'h77;
        enable      = 1'b1;
        push_const(8'h77);
        run_frame(4, -1, 2'd0, 8'h77, 1'b1, 50);
        @(posedge clk); #1;
        check_idle("mid_reset", 0);
        check("sb_after_reset", 32'(exp_q.size()), 32'd0);

        // Diagonal right after reset: (0,0) = frame_cnt = 0.
        reset       = 1'b0;
        pattern_sel = 2'd3;
        enable      = 1'b1;
        push_diag(0);
        run_frame(0, 20, 2'd0, 8'h99, 1'b0, -1);
        @(posedge clk); #1;
        check_idle("final", 1);
        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
